// File: rtl/pc_unit.sv
// pc_unit: registered fetch PC with reset/boot sequencing, branch/JALR/trap redirect,
// squash countdown after redirects and misaligned-target detection.
module pc_unit #(
   parameter int               XLEN          = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR  = '0,
   parameter logic [XLEN-1:0]  BOOT_VECTOR   = 32'h0040_0000,
   parameter int               INSN_BYTES    = 4,
   parameter int               BRANCH_OFFSET = 8,
   parameter int               SQUASH_CYCLES = 2
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   input  logic            i_stall,
   input  logic            i_pc_sel,
   input  logic            i_jalr_flag,
   input  logic [XLEN-1:0] i_branch_off,
   input  logic [XLEN-1:0] i_rs1,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_trap_vector,
   output logic [XLEN-1:0] o_pc,
   output logic            o_pc_valid,
   output logic            o_squash,
   output logic            o_misaligned
);
   localparam int              CW = $clog2(SQUASH_CYCLES + 1);
   localparam logic [CW-1:0]   SQ = CW'(SQUASH_CYCLES);

   typedef enum logic [1:0] {S_RESET, S_BOOT, S_RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt, w_tgt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic            r_mis, w_mis_nxt, w_tgt_mis;

   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) r_state <= S_RESET;
      else            r_state <= w_state_nxt;

   always_comb
      w_state_nxt = (r_state == S_RESET) ? S_BOOT : S_RUN;

   // Branch targets are relative to a PC two fetches ahead of the branch itself
   assign w_tgt     = i_jalr_flag ? ((i_rs1 + i_branch_off) & ~XLEN'(1))
                                  : r_pc + i_branch_off - XLEN'(BRANCH_OFFSET);
   assign w_tgt_mis = |(w_tgt & XLEN'(INSN_BYTES - 1));

   always_comb begin
      w_pc_nxt  = r_pc;
      w_cnt_nxt = r_cnt;
      w_mis_nxt = 1'b0;
      if (r_state == S_BOOT)
         w_pc_nxt = BOOT_VECTOR;
      else if (r_state == S_RUN) begin
         if (i_trap) begin
            w_pc_nxt  = i_trap_vector;
            w_cnt_nxt = SQ;
         end else if (i_pc_sel) begin
            w_pc_nxt  = w_tgt_mis ? i_trap_vector : w_tgt;
            w_cnt_nxt = SQ;
            w_mis_nxt = w_tgt_mis;
         end else if (!i_stall) begin
            w_pc_nxt  = r_pc + XLEN'(INSN_BYTES);
            w_cnt_nxt = r_cnt - CW'(r_cnt != '0);
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         r_pc  <= RESET_VECTOR;
         r_cnt <= '0;
         r_mis <= 1'b0;
      end else begin
         r_pc  <= w_pc_nxt;
         r_cnt <= w_cnt_nxt;
         r_mis <= w_mis_nxt;
      end

   assign o_pc         = r_pc;
   assign o_pc_valid   = (r_state == S_RUN);
   assign o_squash     = (r_cnt != '0);
   assign o_misaligned = r_mis;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test-plan sequences plus randomized traffic against a
// cycle-level behavioural model of the PC unit.
module tb_pc_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        stall = 1'b0, pc_sel = 1'b0, jalr = 1'b0, trap = 1'b0;
   logic [31:0] boff = '0, rs1 = '0, tvec = '0;
   logic [31:0] pc;
   logic        pc_valid, squash, mis;

   int          n_tests = 0, n_fail = 0;
   logic [31:0] m_pc;
   int          m_age, m_cnt;
   logic        m_mis;

   pc_unit dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_pc_sel(pc_sel),
      .i_jalr_flag(jalr), .i_branch_off(boff), .i_rs1(rs1), .i_trap(trap),
      .i_trap_vector(tvec), .o_pc(pc), .o_pc_valid(pc_valid), .o_squash(squash),
      .o_misaligned(mis)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = '0;
      m_age = 0;
      m_cnt = 0;
      m_mis = 1'b0;
   endtask

   // m_age counts edges since reset release: 1 = boot cycle, >=2 = running
   task automatic model_edge();
      logic [31:0] t;
      m_mis = 1'b0;
      if (!rst_n) model_reset();
      else if (m_age < 2) begin
         m_age++;
         if (m_age == 2) m_pc = 32'h0040_0000;
      end else if (trap) begin
         m_pc  = tvec;
         m_cnt = 2;
      end else if (pc_sel) begin
         t = jalr ? ((rs1 + boff) / 2) * 2 : m_pc + boff - 32'd8;
         m_cnt = 2;
         if (t % 4 != 0) begin
            m_pc  = tvec;
            m_mis = 1'b1;
         end else m_pc = t;
      end else if (!stall) begin
         m_pc = m_pc + 32'd4;
         if (m_cnt > 0) m_cnt--;
      end
   endtask

   task automatic compare(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, m_age >= 2});
      check({tag, ".squash"}, {31'b0, squash}, {31'b0, m_cnt > 0});
      check({tag, ".mis"}, {31'b0, mis}, {31'b0, m_mis});
   endtask

   task automatic cyc(input string tag, input logic st, input logic ps, input logic jf,
                      input logic tr, input logic [31:0] off, input logic [31:0] r1,
                      input logic [31:0] tv);
      stall = st; pc_sel = ps; jalr = jf; trap = tr; boff = off; rs1 = r1; tvec = tv;
      @(posedge clk);
      model_edge();
      #1;
      compare(tag);
   endtask

   task automatic idle(input string tag);
      cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h100);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compare(tag);
   endtask

   initial begin
      logic        st, ps, jf, tr;
      logic [31:0] off, r1, tv;
      int          r;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare("reset");
      rst_n = 1'b1;
      idle("boot");
      check("plan_boot_pc", pc, 32'h0);
      idle("run0");
      check("plan_run0", pc, 32'h0040_0000);
      idle("run1");
      idle("run2");
      repeat (3) cyc("stall", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 32'h100);
      check("plan_stall", pc, 32'h0040_0008);
      idle("resume");
      check("plan_resume", pc, 32'h0040_000C);
      idle("pre_br");
      cyc("branch", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, '0, 32'h100);
      check("plan_branch", pc, 32'h0040_0028);
      idle("sq1");
      idle("sq2");
      cyc("jalr", 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 32'h0040_0101, 32'h100);
      check("plan_jalr", pc, 32'h0040_0104);
      cyc("jalr_mis", 1'b0, 1'b1, 1'b1, 1'b0, 32'd6, 32'h0040_0101, 32'h100);
      check("plan_mis_pc", pc, 32'h100);
      check("plan_mis_flag", {31'b0, mis}, 32'd1);
      idle("after_mis");
      cyc("prio", 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, '0, 32'h80);
      check("plan_prio", pc, 32'h80);
      idle("prio_sq");
      cyc("reload", 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, '0, 32'h100);
      idle("reload1");
      idle("reload2");
      cyc("to_top", 1'b0, 1'b1, 1'b1, 1'b0, '0, 32'hFFFF_FFFC, 32'h100);
      idle("wrap");
      check("plan_wrap", pc, 32'h0);
      cyc("br_pre_rst", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, '0, 32'h100);
      async_reset("async_rst");
      check("plan_async_sq", {31'b0, squash}, 32'd0);
      rst_n = 1'b1;
      idle("reboot0");
      idle("reboot1");
      check("plan_reboot", pc, 32'h0040_0000);
      for (int i = 0; i < 400; i++) begin
         r  = $urandom_range(0, 99);
         tr = (r < 5);
         ps = (r >= 5 && r < 25);
         st = ($urandom_range(0, 3) == 0);
         jf = ($urandom_range(0, 1) == 1);
         off = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
         r1  = $urandom;
         tv  = $urandom & ~32'd3;
         cyc("rand", st, ps, jf, tr, off, r1, tv);
         if ($urandom_range(0, 99) < 3) begin
            async_reset("rand_rst");
            rst_n = 1'b1;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
